// File: rtl/uart_loader.sv
// Boot loader: parses MAGIC/LEN/data/CHK frames from the UART byte stream into
// instruction-memory word writes and releases the core only after a good checksum.
module uart_loader #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned TIMEOUT_CLKS = 1000000,
    parameter logic [7:0]  MAGIC        = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int unsigned    TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [16:0]    MAX_LEN  = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        RUN
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [16:0]           word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;

    logic        in_frame, tmo_hit, is_magic, oversize, len_zero;
    logic        byte_last, word_last, chk_ok;
    logic [15:0] len_full;

    assign in_frame  = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};
    // rx_dv takes priority over the timeout terminal count in the same cycle.
    assign tmo_hit   = in_frame && !rx_dv && (tmo_q == TMO_LAST);
    assign is_magic  = (rx_byte == MAGIC);
    assign len_full  = {rx_byte, len_q[7:0]};
    assign oversize  = {1'b0, len_full} > MAX_LEN;
    assign len_zero  = (len_full == 16'd0);
    assign byte_last = (byte_cnt_q == 2'd3);
    assign word_last = ((word_cnt_q + 17'd1) == {1'b0, len_q});
    assign chk_ok    = (rx_byte == sum_q);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= WAIT_MAGIC;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d = state_q;
        if (rx_dv) begin
            unique case (state_q)
                WAIT_MAGIC, RUN: if (is_magic) state_d = LEN_LO;
                LEN_LO:          state_d = LEN_HI;
                LEN_HI: begin
                    if (oversize)      state_d = WAIT_MAGIC;
                    else if (len_zero) state_d = CHECK;
                    else               state_d = DATA;
                end
                DATA:            if (byte_last && word_last) state_d = CHECK;
                CHECK:           state_d = chk_ok ? RUN : WAIT_MAGIC;
                default:         state_d = WAIT_MAGIC;
            endcase
        end else if (tmo_hit) begin
            state_d = WAIT_MAGIC;
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        sum_d       = sum_q;
        wdata_d     = wdata_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        tmo_d       = (!in_frame || rx_dv || tmo_hit) ? '0 : tmo_q + TW'(1);

        if (rx_dv) begin
            unique case (state_q)
                WAIT_MAGIC, RUN: begin
                    if (is_magic) begin
                        load_err_d  = 1'b0;
                        load_done_d = 1'b0;
                        sum_d       = 8'h00;
                        byte_cnt_d  = 2'd0;
                        word_cnt_d  = 17'd0;
                        mem_addr_d  = '0;
                    end
                end
                LEN_LO: len_d[7:0] = rx_byte;
                LEN_HI: begin
                    len_d[15:8] = rx_byte;
                    if (oversize) load_err_d = 1'b1;
                end
                DATA: begin
                    // Little-endian: first byte ends up in bits [7:0].
                    wdata_d    = {rx_byte, wdata_q[31:8]};
                    sum_d      = sum_q + rx_byte;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_last) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = word_cnt_q[ADDR_WIDTH-1:0];
                        word_cnt_d = word_cnt_q + 17'd1;
                    end
                end
                CHECK: begin
                    if (chk_ok) load_done_d = 1'b1;
                    else        load_err_d  = 1'b1;
                end
                default: ;
            endcase
        end else if (tmo_hit) begin
            load_err_d = 1'b1;
        end

        cpu_rst_d = (state_d != RUN);
        busy_d    = (state_d != WAIT_MAGIC) && (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            wdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            wdata_q     <= wdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed corner cases plus random frames,
// with expected writes and status derived from how each frame was built.
module tb_uart_loader;

    localparam int          AW    = 4;
    localparam int          TMO   = 64;
    localparam logic [7:0]  MAGIC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          load_done;
    logic          load_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] words [16];

    uart_loader #(
        .ADDR_WIDTH  (AW),
        .TIMEOUT_CLKS(TMO),
        .MAGIC       (MAGIC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    // Each sampled cycle with mem_we high is one memory write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send(input logic [7:0] b, input int gap);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    function automatic int pick_gap(input int mode);
        return (mode < 0) ? int'($urandom_range(0, 6)) : mode;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_rst"},   32'(cpu_rst),   32'd1);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_load_done"}, 32'(load_done), 32'd0);
        check({tag, "_load_err"},  32'(load_err),  32'd0);
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
        check({tag, "_load_done"}, 32'(load_done), 32'(exp_done));
        check({tag, "_load_err"},  32'(load_err),  32'(exp_err));
        check({tag, "_cpu_rst"},   32'(cpu_rst),   32'(!exp_done));
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Sends a frame of words[0..len-1]; checksum is the byte sum of the data,
    // optionally corrupted. Expected writes are simply the words in order.
    task automatic send_frame(input string tag, input int len, input bit bad_chk, input int gap_mode);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [15:0] len16;
        sum   = 8'h00;
        len16 = 16'(len);
        wr_q.delete();
        send(MAGIC, 0);
        check({tag, "_magic_cpu_rst"}, 32'(cpu_rst),   32'd1);
        check({tag, "_magic_busy"},    32'(busy),      32'd1);
        check({tag, "_magic_done"},    32'(load_done), 32'd0);
        check({tag, "_magic_err"},     32'(load_err),  32'd0);
        repeat (pick_gap(gap_mode)) @(negedge clk);
        send(len16[7:0], pick_gap(gap_mode));
        send(len16[15:8], pick_gap(gap_mode));
        for (int w = 0; w < len; w++) begin
            for (int k = 0; k < 4; k++) begin
                b   = words[w][8*k +: 8];
                sum = sum + b;
                send(b, pick_gap(gap_mode));
            end
        end
        send(bad_chk ? (sum ^ 8'h01) : sum, 0);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(len));
        for (int w = 0; w < len && w < wr_q.size(); w++) begin
            check($sformatf("%s_addr%0d", tag, w), 32'(wr_q[w].addr), 32'(w));
            check($sformatf("%s_data%0d", tag, w), wr_q[w].data, words[w]);
        end
        check_status(tag, !bad_chk, bad_chk);
    endtask

    initial begin
        logic [7:0] noise [3];
        int         len;
        bit         bad;

        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Non-magic bytes while idle are ignored.
        noise = '{8'h00, 8'hFF, 8'h12};
        wr_q.delete();
        for (int i = 0; i < 3; i++) begin
            send(noise[i], 1);
            check($sformatf("noise%0d_busy", i), 32'(busy), 32'd0);
        end
        check("noise_cpu_rst", 32'(cpu_rst), 32'd1);
        check("noise_nwrites", 32'(wr_q.size()), 32'd0);

        // Two-word load; checksum of 13 00 00 00 EF BE AD DE is 0x4B.
        words[0] = 32'h0000_0013;
        words[1] = 32'hDEAD_BEEF;
        send_frame("two_word", 2, 1'b0, -1);

        // Non-magic byte in RUN keeps the core running.
        send(8'h00, 1);
        check("run_noise_done",    32'(load_done), 32'd1);
        check("run_noise_cpu_rst", 32'(cpu_rst),   32'd0);

        // Reload from RUN with a corrupted checksum: writes still land, then abort.
        send_frame("bad_chk", 2, 1'b1, -1);

        // Empty frame: checksum 0, no writes.
        send_frame("len0", 0, 1'b0, -1);

        // Oversize length (17 > 16 words) aborts right after LEN_HI.
        wr_q.delete();
        send(MAGIC, 0);
        send(8'd17, 0);
        send(8'd0, 0);
        check_status("oversize", 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("oversize_nwrites", 32'(wr_q.size()), 32'd0);

        // Full-depth frame with bytes on consecutive cycles.
        for (int w = 0; w < 16; w++) words[w] = $urandom;
        send_frame("full_b2b", 16, 1'b0, 0);

        // A byte arriving exactly on the timeout terminal count is accepted.
        words[0] = $urandom;
        send_frame("tmo_edge", 1, 1'b0, TMO - 1);

        // Idle timeout inside DATA.
        wr_q.delete();
        send(MAGIC, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        repeat (TMO - 2) @(negedge clk);
        check("tmo_early_err",  32'(load_err), 32'd0);
        check("tmo_early_busy", 32'(busy),     32'd1);
        repeat (2) @(negedge clk);
        check_status("tmo", 1'b0, 1'b1);
        check("tmo_nwrites", 32'(wr_q.size()), 32'd0);

        // Random frames with random inter-byte gaps.
        for (int f = 0; f < 8; f++) begin
            len = int'($urandom_range(1, 16));
            bad = ($urandom_range(0, 3) == 0);
            for (int w = 0; w < len; w++) words[w] = $urandom;
            send_frame($sformatf("rand%0d", f), len, bad, -1);
        end

        // Reset in the middle of DATA returns everything to reset values.
        send(MAGIC, 0);
        send(8'd3, 0);
        send(8'd0, 0);
        for (int i = 0; i < 5; i++) send(8'(i + 8'h41), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        rst = 1'b0;
        @(negedge clk);

        for (int w = 0; w < 3; w++) words[w] = $urandom;
        send_frame("after_rst", 3, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
